// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: four patterns, key-stepped mode.
// Define VGA_BORDER_EN to draw an all-ones border around the active area.
module vga_pattern_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0,
    parameter int COLOR_W   = 4,
    parameter int BAR_COUNT = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               MODE_STEP,
    input  logic               INVERT,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B,
    output logic               DE,
    output logic               FRAME_START,
    output logic [1:0]         MODE
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / BAR_COUNT;
    localparam int BAR_H   = V_ACTIVE / BAR_COUNT;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int SH_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int SV_W    = (BAR_H > 1) ? $clog2(BAR_H) : 1;
    localparam int BI_W    = ($clog2(BAR_COUNT + 1) > 3) ?
                             $clog2(BAR_COUNT + 1) : 3;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HC_W-1:0]  H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0]  H_ACT    = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0]  HS_BEG   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0]  HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]  V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0]  V_ACT    = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0]  VS_BEG   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0]  VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(BAR_W - 1);
    localparam logic [SV_W-1:0]  SV_LAST  = SV_W'(BAR_H - 1);
    localparam logic [BI_W-1:0]  BI_MAX   = BI_W'(BAR_COUNT);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);
`ifdef VGA_BORDER_EN
    localparam logic [HC_W-1:0]  H_ALAST  = HC_W'(H_ACTIVE - 1);
    localparam logic [VC_W-1:0]  V_ALAST  = VC_W'(V_ACTIVE - 1);
`endif

    logic [DIV_W-1:0]   div_q, div_d;
    logic [HC_W-1:0]    h_cnt_q, h_cnt_d;
    logic [VC_W-1:0]    v_cnt_q, v_cnt_d;
    logic [SH_W-1:0]    sub_h_q, sub_h_d;
    logic [SV_W-1:0]    sub_v_q, sub_v_d;
    logic [BI_W-1:0]    bx_q, bx_d;
    logic [BI_W-1:0]    by_q, by_d;
    logic [2:0]         frame_cnt_q, frame_cnt_d;
    logic [1:0]         pending_q, pending_d;
    logic [1:0]         mode_q, mode_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic               de_q, de_d;
    logic               fs_q, fs_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;

    logic                 pe;
    logic                 h_last;
    logic                 v_last;
    logic                 frame_end;
    logic                 active;
    logic                 in_bars;
    logic [2:0]           code;
    logic [3*COLOR_W-1:0] rgb;

    assign pe        = (div_q == DIV_LAST);
    assign h_last    = (h_cnt_q == H_LAST);
    assign v_last    = (v_cnt_q == V_LAST);
    assign frame_end = h_last && v_last;

    // Pixel colour from the pre-increment counters.
    always_comb begin
        active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        in_bars = (bx_q < BI_MAX) && (by_q < BI_MAX);
        case (mode_q)
            2'd0:    code = 3'd7 - bx_q[2:0];
            2'd1:    code = 3'd7 - by_q[2:0];
            2'd2:    code = (3'd7 - bx_q[2:0]) ^ (3'd7 - by_q[2:0]);
            default: code = frame_cnt_q;
        endcase
        if (!in_bars) begin
            code = 3'd0;
        end
        rgb = {{COLOR_W{code[2]}}, {COLOR_W{code[1]}}, {COLOR_W{code[0]}}};
        if (INVERT) begin
            rgb = ~rgb;
        end
`ifdef VGA_BORDER_EN
        if (h_cnt_q == '0 || h_cnt_q == H_ALAST ||
            v_cnt_q == '0 || v_cnt_q == V_ALAST) begin
            rgb = '1;
        end
`endif
        if (!active) begin
            rgb = '0;
        end
    end

    always_comb begin
        div_d       = pe ? '0 : div_q + DIV_W'(1);
        pending_d   = MODE_STEP ? pending_q + 2'd1 : pending_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        sub_h_d     = sub_h_q;
        sub_v_d     = sub_v_q;
        bx_d        = bx_q;
        by_d        = by_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        hs_d        = hs_q;
        vs_d        = vs_q;
        de_d        = de_q;
        fs_d        = fs_q;
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        if (pe) begin
            if (h_last) begin
                h_cnt_d = '0;
                sub_h_d = '0;
                bx_d    = '0;
                if (v_last) begin
                    v_cnt_d = '0;
                    sub_v_d = '0;
                    by_d    = '0;
                end else begin
                    v_cnt_d = v_cnt_q + VC_W'(1);
                    if (sub_v_q == SV_LAST) begin
                        sub_v_d = '0;
                        if (by_q != BI_MAX) by_d = by_q + BI_W'(1);
                    end else begin
                        sub_v_d = sub_v_q + SV_W'(1);
                    end
                end
            end else begin
                h_cnt_d = h_cnt_q + HC_W'(1);
                // Bar index saturates: anything past the last bar is black.
                if (sub_h_q == SH_LAST) begin
                    sub_h_d = '0;
                    if (bx_q != BI_MAX) bx_d = bx_q + BI_W'(1);
                end else begin
                    sub_h_d = sub_h_q + SH_W'(1);
                end
            end
            if (frame_end) begin
                frame_cnt_d = frame_cnt_q + 3'd1;
                mode_d      = pending_d;
            end
            hs_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ?
                   SYNC_ON : ~SYNC_ON;
            vs_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ?
                   SYNC_ON : ~SYNC_ON;
            de_d = active;
            fs_d = (h_cnt_q == '0) && (v_cnt_q == '0);
            r_d  = rgb[3*COLOR_W-1:2*COLOR_W];
            g_d  = rgb[2*COLOR_W-1:COLOR_W];
            b_d  = rgb[COLOR_W-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_q       <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            sub_h_q     <= '0;
            sub_v_q     <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            frame_cnt_q <= '0;
            pending_q   <= '0;
            mode_q      <= '0;
            hs_q        <= ~SYNC_ON;
            vs_q        <= ~SYNC_ON;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
        end else begin
            div_q       <= div_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            sub_h_q     <= sub_h_d;
            sub_v_q     <= sub_v_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            frame_cnt_q <= frame_cnt_d;
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign DE          = de_q;
    assign FRAME_START = fs_q;
    assign MODE        = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster; arithmetic reference model.
// Honours VGA_BORDER_EN when the design is built with it.
module tb_vga_pattern_gen;

    localparam int CD  = 2;
    localparam int HA  = 44;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HB  = 6;
    localparam int VA  = 26;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int BC  = 8;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;
    localparam int FT  = HT * VT;
    localparam int BW  = HA / BC;
    localparam int BH  = VA / BC;
    localparam bit SP  = 1'b0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [11:0] rgb;
        logic [1:0]  md;
    } obs_t;

    typedef struct {
        int          md;
        bit          inv;
        int          h;
        int          v;
        logic [11:0] rgb;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       MODE_STEP;
    logic       INVERT;
    logic       VGA_HS;
    logic       VGA_VS;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       DE;
    logic       FRAME_START;
    logic [1:0] MODE;

    int   checks = 0;
    int   errors = 0;
    int   e = 0;
    int   steps = 0;
    int   mode_m = 0;
    int   pix_mode = 0;
    logic inv_pe = 1'b0;
    int   cur_h = -1;
    int   cur_v = -1;

    vga_pattern_gen #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(0), .COLOR_W(4), .BAR_COUNT(BC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .MODE_STEP(MODE_STEP), .INVERT(INVERT),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .DE(DE), .FRAME_START(FRAME_START), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Expected outputs after k pixel edges since reset release.
    function automatic obs_t expect_at(int k, int md, logic inv, int mm);
        obs_t o;
        int p, h, v, f, bx, by, c;
        o    = '0;
        o.hs = !SP;
        o.vs = !SP;
        o.md = mm[1:0];
        if (k == 0) return o;
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        f = p / FT;
        o.hs = (h >= HA + HF && h < HA + HF + HSW) ? SP : !SP;
        o.vs = (v >= VA + VF && v < VA + VF + VSW) ? SP : !SP;
        o.de = (h < HA) && (v < VA);
        o.fs = (h == 0) && (v == 0);
        if (o.de) begin
            bx = h / BW;
            by = v / BH;
            if (bx >= BC || by >= BC) c = 0;
            else if (md == 0) c = 7 - bx;
            else if (md == 1) c = 7 - by;
            else if (md == 2) c = (7 - bx) ^ (7 - by);
            else c = f % 8;
            o.rgb = {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
            if (inv) o.rgb = ~o.rgb;
`ifdef VGA_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) o.rgb = '1;
`endif
        end
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {VGA_HS, VGA_VS, DE, FRAME_START, VGA_R, VGA_G, VGA_B, MODE};
    endfunction

    task automatic check_obs(string nm, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic check_int(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, got, exp);
        end
    endtask

    // One CLK: update model from inputs seen at the edge, compare at negedge.
    task automatic tick();
        int k;
        @(posedge CLK);
        if (RESET) begin
            e        = 0;
            steps    = 0;
            mode_m   = 0;
            pix_mode = 0;
            inv_pe   = 1'b0;
        end else begin
            e++;
            if (MODE_STEP) steps = (steps + 1) % 4;
            if (e % CD == 0) begin
                pix_mode = mode_m;
                inv_pe   = INVERT;
                if ((e / CD) % FT == 0) mode_m = steps;
            end
        end
        @(negedge CLK);
        k = e / CD;
        check_obs("cycle", dut_obs(), expect_at(k, pix_mode, inv_pe, mode_m));
        if (k == 0) begin
            cur_h = -1;
            cur_v = -1;
        end else begin
            cur_h = (k - 1) % HT;
            cur_v = ((k - 1) / HT) % VT;
        end
    endtask

    // Advance until pixel (h,v) has just been registered (optionally in mode md).
    task automatic wait_px(int h, int v, int md);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < 3 * FT * CD) begin
            tick();
            n++;
            hit = (e % CD == 0) && cur_h == h && cur_v == v &&
                  (md < 0 || pix_mode == md);
        end
        if (!hit) check_int("wait_px_timeout", n, -1);
    endtask

    task automatic pulse_step();
        MODE_STEP = 1'b1;
        tick();
        MODE_STEP = 1'b0;
    endtask

    vec_t vecs[12];
    obs_t rst_exp;

    initial begin
        int n;
        vecs[0]  = '{0, 1'b0,  1,  1, 12'hFFF};
        vecs[1]  = '{0, 1'b0,  5,  1, 12'hFF0};
        vecs[2]  = '{0, 1'b0, 39,  1, 12'h000};
        vecs[3]  = '{0, 1'b0, 41,  1, 12'h000};
        vecs[4]  = '{0, 1'b1, 36,  2, 12'hFFF};
        vecs[5]  = '{0, 1'b1,  2,  3, 12'h000};
        vecs[6]  = '{0, 1'b1, 50,  3, 12'h000};
        vecs[7]  = '{1, 1'b0, 10,  4, 12'hFF0};
        vecs[8]  = '{1, 1'b0, 20,  7, 12'hF0F};
        vecs[9]  = '{1, 1'b0, 20, 24, 12'h000};
        vecs[10] = '{2, 1'b0, 12,  4, 12'h0FF};
        vecs[11] = '{2, 1'b0, 35, 10, 12'hF00};

        rst_exp    = '0;
        rst_exp.hs = !SP;
        rst_exp.vs = !SP;

        RESET     = 1'b1;
        MODE_STEP = 1'b0;
        INVERT    = 1'b0;
        repeat (3) tick();
        check_obs("reset_state", dut_obs(), rst_exp);
        RESET = 1'b0;

        // Steps accumulate within a frame; the last one lands on the boundary.
        wait_px(0, 5, -1);
        pulse_step();
        check_int("mode_hold_1", int'(MODE), 0);
        wait_px(0, 15, -1);
        pulse_step();
        n = 0;
        while (!(((e + 1) % CD == 0) && (((e + 1) / CD) % FT == 0)) &&
               n < FT * CD) begin
            tick();
            n++;
        end
        check_int("mode_pre_boundary", int'(MODE), 0);
        pulse_step();
        check_int("mode_after_triple", int'(MODE), 3);
        wait_px(10, 10, 3);
        check_int("solid_frame1", int'({VGA_R, VGA_G, VGA_B}), 12'h00F);
        wait_px(10, 10, 3);
        check_int("solid_frame2", int'({VGA_R, VGA_G, VGA_B}), 12'h0F0);

        // Mid-frame reset, then first FRAME_START one pixel after release.
        wait_px(5, 20, -1);
        RESET = 1'b1;
        #1;
        check_obs("reset_async", dut_obs(), rst_exp);
        repeat (3) tick();
        RESET = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!FRAME_START && n < 20);
        check_int("fs_after_release", n, CD);

        foreach (vecs[i]) begin
            while (steps != vecs[i].md) pulse_step();
            INVERT = vecs[i].inv;
            wait_px(vecs[i].h, vecs[i].v, vecs[i].md);
            check_int($sformatf("vec%0d", i),
                      int'({VGA_R, VGA_G, VGA_B}), int'(vecs[i].rgb));
        end
        INVERT = 1'b0;

        repeat (6 * FT * CD) begin
            MODE_STEP = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 599) == 0) INVERT = ~INVERT;
            tick();
        end
        MODE_STEP = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
